// File: rtl/sonar_pkg.sv
// Shared types and helpers for the sonar rangefinder scheduler.
//   sonar_state_t   : scheduler FSM states (also exported on the debug port)
//   sonar_result_t  : one tagged measurement result (id, width in us, timeout)
//   next_masked_idx : round-robin pick of the first masked sensor at/after ptr
package sonar_pkg;

  localparam int MAX_SENSORS = 8;
  localparam int RES_US_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_ECHO = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } sonar_state_t;

  typedef struct packed {
    logic [2:0]          id;
    logic [RES_US_W-1:0] us;
    logic                timeout;
  } sonar_result_t;

  // Scans n sensors starting at ptr, wrapping n-1 -> 0. Returns ptr when
  // the mask is empty; callers only use the result when |mask.
  function automatic logic [2:0] next_masked_idx(
    input logic [MAX_SENSORS-1:0] mask,
    input logic [2:0]             ptr,
    input int                     n
  );
    logic [2:0] idx;
    logic       found;
    next_masked_idx = ptr;
    found           = 1'b0;
    for (int i = 0; i < MAX_SENSORS; i++) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i < n && !found && mask[idx]) begin
        next_masked_idx = idx;
        found           = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running microsecond tick generator.
//   i_clk   : clock
//   i_reset : synchronous active-high reset (prescaler back to 0)
//   o_tick  : one-cycle pulse every CLK_PER_US clocks
module us_tick_gen #(
  parameter int CLK_PER_US = 40
) (
  input  logic i_clk,
  input  logic i_reset,
  output logic o_tick
);

  localparam int W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_US - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin trigger/echo controller for up to 8 ultrasonic rangefinders.
// One sensor is served per slot: a TRIG_US trigger pulse, then wait for the
// echo rise, measure its width in us, post one tagged result, and hold off
// until the slot (measured from trigger rise) reaches SLOT_US.
//
// Handshake: o_result_valid is a one-cycle pulse with no ready; the consumer
// must capture o_result_id/us/timeout on that cycle (they also hold until the
// next result).
//
// Ports:
//   i_clk, i_reset     : clock, synchronous active-high reset
//   i_enable           : run scheduling; low finishes current slot then idles
//   i_sensor_mask      : sensors taking part in the rotation (sampled in IDLE)
//   i_echo             : asynchronous echo lines
//   o_trig             : trigger lines, one-hot or zero
//   o_busy             : a slot is in progress
//   o_result_valid     : one-cycle result pulse
//   o_result_id/us/timeout : registered result fields
//   o_state            : debug view of the FSM state (sonar_state_t encoding)
module sonar_scheduler
  import sonar_pkg::*;
#(
  parameter int N_SENSORS  = 4,
  parameter int CLK_PER_US = 40,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int SLOT_US    = 60000,
  parameter int CW         = 16     // at most RES_US_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [N_SENSORS-1:0] i_sensor_mask,
  input  logic [N_SENSORS-1:0] i_echo,
  output logic [N_SENSORS-1:0] o_trig,
  output logic                 o_busy,
  output logic                 o_result_valid,
  output logic [2:0]           o_result_id,
  output logic [CW-1:0]        o_result_us,
  output logic                 o_result_timeout,
  output logic [2:0]           o_state
);

  localparam logic [CW-1:0] TRIG_LAST = CW'(TRIG_US - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_US - 1);
  localparam logic [CW-1:0] TO_FULL   = CW'(TIMEOUT_US);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_US - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(SLOT_US);

  sonar_state_t            r_state, w_next_state;
  logic [2:0]              r_sel, r_ptr, w_pick, w_trig_idx;
  logic [CW-1:0]           r_slot_us, r_width, w_post_us;
  logic [N_SENSORS-1:0]    r_echo_s1, r_echo_s2, r_trig, w_trig;
  logic [MAX_SENSORS-1:0]  w_mask8, w_echo8;
  logic                    r_echo_d, w_echo_sel, w_rise, w_fall;
  logic                    w_tick, w_post, w_post_to;
  sonar_result_t           r_result;
  logic                    r_result_valid;

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_tick  (w_tick)
  );

  // Widen mask/echo to 8 bits so a 3-bit sensor index selects exactly.
  always_comb begin
    w_mask8 = '0;
    w_echo8 = '0;
    w_mask8[N_SENSORS-1:0] = i_sensor_mask;
    w_echo8[N_SENSORS-1:0] = r_echo_s2;
  end

  assign w_pick     = next_masked_idx(w_mask8, r_ptr, N_SENSORS);
  assign w_echo_sel = w_echo8[r_sel];
  assign w_rise     = w_echo_sel & ~r_echo_d;
  assign w_fall     = ~w_echo_sel & r_echo_d;

  // Next state and result posting.
  always_comb begin
    w_next_state = r_state;
    w_post       = 1'b0;
    w_post_us    = '0;
    w_post_to    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && |i_sensor_mask) w_next_state = S_TRIG;
      end
      S_TRIG: begin
        if (w_tick && r_slot_us == TRIG_LAST) w_next_state = S_WAIT_ECHO;
      end
      S_WAIT_ECHO: begin
        // Echo already high at trigger end never produces a rise here.
        if (w_rise) begin
          w_next_state = S_MEASURE;
        end else if (w_tick && r_width == TO_LAST) begin
          w_post       = 1'b1;
          w_post_to    = 1'b1;
          w_next_state = S_HOLDOFF;
        end
      end
      S_MEASURE: begin
        if (w_fall) begin
          w_post       = 1'b1;
          w_post_us    = r_width;
          w_next_state = S_HOLDOFF;
        end else if (w_tick && r_width == TO_LAST) begin
          w_post       = 1'b1;
          w_post_us    = TO_FULL;
          w_post_to    = 1'b1;
          w_next_state = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        // Worst case (full wait plus full width) can overrun a short slot;
        // leave immediately rather than wait for the counter to wrap.
        if (r_slot_us >= SLOT_END || (w_tick && r_slot_us == SLOT_LAST))
          w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Trigger decode from the next state so o_trig is high exactly in TRIG.
  assign w_trig_idx = (r_state == S_IDLE) ? w_pick : r_sel;
  always_comb begin
    w_trig = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      w_trig[k] = (w_next_state == S_TRIG) && (w_trig_idx == 3'(k));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_sel          <= '0;
      r_ptr          <= '0;
      r_slot_us      <= '0;
      r_width        <= '0;
      r_echo_s1      <= '0;
      r_echo_s2      <= '0;
      r_echo_d       <= 1'b0;
      r_trig         <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_echo_s1 <= i_echo;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= w_echo_sel;
      r_trig    <= w_trig;

      if (r_state == S_IDLE && w_next_state == S_TRIG) begin
        r_sel     <= w_pick;
        r_slot_us <= '0;
      end else if (w_tick && r_state != S_IDLE) begin
        r_slot_us <= r_slot_us + 1'b1;
      end

      // r_width is the echo-wait timer in WAIT_ECHO and the width in MEASURE.
      if ((r_state == S_TRIG && w_next_state == S_WAIT_ECHO) ||
          (r_state == S_WAIT_ECHO && w_next_state == S_MEASURE)) begin
        r_width <= '0;
      end else if (w_tick && (r_state == S_WAIT_ECHO ||
                              (r_state == S_MEASURE && w_echo_sel))) begin
        r_width <= r_width + 1'b1;
      end

      if (r_state == S_HOLDOFF && w_next_state == S_IDLE) begin
        r_ptr <= (r_sel == 3'(N_SENSORS - 1)) ? 3'd0 : r_sel + 3'd1;
      end

      r_result_valid <= w_post;
      if (w_post) begin
        r_result.id      <= r_sel;
        r_result.us      <= RES_US_W'(w_post_us);
        r_result.timeout <= w_post_to;
      end
    end
  end

  assign o_trig           = r_trig;
  assign o_busy           = (r_state != S_IDLE);
  assign o_result_valid   = r_result_valid;
  assign o_result_id      = r_result.id;
  assign o_result_us      = r_result.us[CW-1:0];
  assign o_result_timeout = r_result.timeout;
  assign o_state          = r_state;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler at CLK_PER_US=4, TRIG_US=10,
// TIMEOUT_US=200, SLOT_US=500. A table of per-slot vectors drives the
// rotation; hand-written sequences cover enable drop, empty mask and reset
// in the middle of a measurement.
module tb_sonar_scheduler;

  localparam int N   = 4;
  localparam int CPU = 4;

  logic         clk;
  logic         i_reset, i_enable;
  logic [N-1:0] i_sensor_mask, i_echo;
  logic [N-1:0] o_trig;
  logic         o_busy, o_result_valid, o_result_timeout;
  logic [2:0]   o_result_id, o_state;
  logic [15:0]  o_result_us;

  sonar_scheduler #(
    .N_SENSORS(N), .CLK_PER_US(CPU), .TRIG_US(10),
    .TIMEOUT_US(200), .SLOT_US(500), .CW(16)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_sensor_mask(i_sensor_mask), .i_echo(i_echo),
    .o_trig(o_trig), .o_busy(o_busy), .o_result_valid(o_result_valid),
    .o_result_id(o_result_id), .o_result_us(o_result_us),
    .o_result_timeout(o_result_timeout), .o_state(o_state)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, want %0d..%0d", nm, act, lo, hi);
  endtask

  // ---------------- monitor ----------------
  typedef struct {
    int     id;
    int     us;
    int     to;
    longint since_fall;
  } res_t;

  res_t   res_q[$];
  longint rise_q[$];
  longint width_q[$];
  longint cyc = 0, last_rise = 0, last_fall = 0;
  int     n_valid = 0, n_rises = 0, multi_hot = 0, double_valid = 0;

  initial begin
    logic [N-1:0] prev_trig;
    logic         prev_valid;
    res_t         r;
    prev_trig  = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_result_valid === 1'b1) begin
        n_valid++;
        if (prev_valid) double_valid++;
        r.id = int'(o_result_id);
        r.us = int'(o_result_us);
        r.to = int'(o_result_timeout);
        r.since_fall = cyc - last_fall;
        res_q.push_back(r);
      end
      if ($countones(o_trig) > 1) multi_hot++;
      if (prev_trig == '0 && o_trig != '0) begin
        rise_q.push_back(cyc);
        last_rise = cyc;
        n_rises++;
      end
      if (prev_trig != '0 && o_trig == '0) begin
        width_q.push_back(cyc - last_rise);
        last_fall = cyc;
      end
      prev_trig  = o_trig;
      prev_valid = (o_result_valid === 1'b1);
    end
  end

  // ---------------- echo responder ----------------
  // On each trigger fall, raise that sensor's echo after resp_delay us for
  // resp_width us (width 0 = sensor stays silent).
  int resp_delay = 0;
  int resp_width = 0;

  initial begin
    logic [N-1:0] prev;
    int           k;
    i_echo = '0;
    prev   = '0;
    forever begin
      @(negedge clk);
      if (prev != '0 && o_trig == '0 && resp_width > 0) begin
        k = 0;
        for (int b = 0; b < N; b++) if (prev[b]) k = b;
        repeat (resp_delay * CPU) @(negedge clk);
        i_echo[k] = 1'b1;
        repeat (resp_width * CPU) @(negedge clk);
        i_echo[k] = 1'b0;
      end
      prev = o_trig;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_result(input string nm, input int id, input int lo, input int hi,
                               input int to, input int lat_lo, input int lat_hi);
    res_t r;
    bit   got;
    got = 1'b0;
    for (int c = 0; c < 4000 && !got; c++) begin
      @(negedge clk);
      if (res_q.size() > 0) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL %s: no result_valid within 4000 cycles", nm);
      return;
    end
    r = res_q.pop_front();
    chk({nm, " id"}, r.id, id, id);
    chk({nm, " us"}, r.us, lo, hi);
    chk({nm, " timeout"}, r.to, to, to);
    if (lat_lo >= 0) chk({nm, " post latency clks"}, r.since_fall, lat_lo, lat_hi);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] mask;
    int         delay_us;
    int         width_us;
    int         exp_id;
    int         exp_lo;
    int         exp_hi;
    int         exp_to;
    int         lat_lo;
    int         lat_hi;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int v_rises;
    // mask, delay, width -> id, us range, timeout, post latency after trig fall
    vecs[0] = '{4'b1011, 20,  50, 0,  49,  51, 0,  -1,  -1};
    vecs[1] = '{4'b1011, 30,  80, 1,  79,  81, 0,  -1,  -1};
    vecs[2] = '{4'b1011, 10, 120, 3, 119, 121, 0,  -1,  -1};
    vecs[3] = '{4'b1011, 40,  30, 0,  29,  31, 0,  -1,  -1};
    vecs[4] = '{4'b0100,  0,   0, 2,   0,   0, 1, 799, 801};
    vecs[5] = '{4'b0001, 120, 150, 0, 149, 151, 0,  -1,  -1};
    vecs[6] = '{4'b0010,  5, 300, 1, 200, 200, 1,  -1,  -1};
    vecs[7] = '{4'b1000,  0,  10, 3,   9,  11, 0,  -1,  -1};
    vecs[8] = '{4'b1111, 100, 195, 0, 194, 196, 0,  -1,  -1};

    // reset state
    i_reset = 1'b1; i_enable = 1'b0; i_sensor_mask = '0;
    repeat (5) @(negedge clk);
    chk("reset trig",    o_trig, 0, 0);
    chk("reset busy",    o_busy, 0, 0);
    chk("reset valid",   o_result_valid, 0, 0);
    chk("reset id",      o_result_id, 0, 0);
    chk("reset us",      o_result_us, 0, 0);
    chk("reset timeout", o_result_timeout, 0, 0);
    chk("reset state",   o_state, 0, 0);
    i_reset = 1'b0;
    i_sensor_mask = 4'b1011;
    repeat (20) @(negedge clk);
    chk("enable low stays idle", o_busy, 0, 0);

    // table-driven rotation, enable held high, slots back to back
    rise_q.delete();
    width_q.delete();
    for (int i = 0; i < 9; i++) begin
      i_sensor_mask = vecs[i].mask;
      resp_delay    = vecs[i].delay_us;
      resp_width    = vecs[i].width_us;
      i_enable      = 1'b1;
      expect_result($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_lo,
                    vecs[i].exp_hi, vecs[i].exp_to, vecs[i].lat_lo, vecs[i].lat_hi);
    end
    chk("table trig pulses", rise_q.size(), 9, 9);
    foreach (width_q[i]) chk($sformatf("trig%0d width clks", i), width_q[i], 37, 40);
    for (int i = 1; i < rise_q.size(); i++)
      chk($sformatf("slot%0d spacing clks", i), rise_q[i] - rise_q[i-1], 1998, 2001);

    // enable drops 50 us into a slot: result still posted, then idle
    resp_delay = 20;
    resp_width = 60;
    begin
      int r0;
      bit seen;
      r0 = n_rises;
      seen = 1'b0;
      for (int c = 0; c < 3000 && !seen; c++) begin
        @(negedge clk);
        if (n_rises != r0) seen = 1'b1;
      end
      chk("enable-drop slot started", int'(seen), 1, 1);
    end
    repeat (200) @(negedge clk);
    i_enable = 1'b0;
    expect_result("enable-drop", 1, 59, 61, 0, -1, -1);
    begin
      bit idle;
      idle = 1'b0;
      for (int c = 0; c < 2500 && !idle; c++) begin
        @(negedge clk);
        if (!o_busy) idle = 1'b1;
      end
      chk("enable-drop busy falls", int'(idle), 1, 1);
    end
    v_rises = n_rises;
    begin
      int bad;
      bad = 0;
      repeat (1000) begin
        @(negedge clk);
        if (o_trig != '0 || o_busy) bad++;
      end
      chk("enable-drop stays idle cycles", bad, 0, 0);
    end
    chk("enable-drop no new trig", n_rises, v_rises, v_rises);
    chk("enable-drop no extra result", res_q.size(), 0, 0);

    // empty mask with enable high stays idle
    i_sensor_mask = '0;
    i_enable      = 1'b1;
    repeat (600) @(negedge clk);
    chk("empty mask busy", o_busy, 0, 0);
    chk("empty mask no trig", n_rises, v_rises, v_rises);

    // reset during MEASURE: sensor 2 (pointer is 2 after the sensor-1 slot)
    i_sensor_mask = 4'b0100;
    resp_delay    = 10;
    resp_width    = 300;
    begin
      bit meas;
      int nv;
      meas = 1'b0;
      for (int c = 0; c < 3000 && !meas; c++) begin
        @(negedge clk);
        if (o_state == 3'd3) meas = 1'b1;
      end
      chk("reached MEASURE", int'(meas), 1, 1);
      chk("MEASURE trig low", o_trig, 0, 0);
      repeat (40) @(negedge clk);
      nv = n_valid;
      i_reset = 1'b1;
      @(negedge clk);
      chk("mid-reset trig",  o_trig, 0, 0);
      chk("mid-reset busy",  o_busy, 0, 0);
      chk("mid-reset valid", o_result_valid, 0, 0);
      chk("mid-reset state", o_state, 0, 0);
      repeat (1300) @(negedge clk);
      chk("mid-reset no post", n_valid, nv, nv);
      chk("mid-reset queue", res_q.size(), 0, 0);
    end
    i_sensor_mask = 4'b1111;
    resp_delay    = 10;
    resp_width    = 40;
    i_reset       = 1'b0;
    expect_result("post-reset restart", 0, 39, 41, 0, -1, -1);

    chk("trig never multi-hot", multi_hot, 0, 0);
    chk("valid single cycle", double_valid, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
